// File: rtl/lc3_exec_pkg.sv
// Shared definitions for the LC-3 execute stage: opcodes, ALU control encoding,
// PC offset selects and the sign-extension helper.
package lc3_exec_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_AND  = 2'b01,
    ALU_NOT  = 2'b10,
    ALU_RSVD = 2'b11
  } alu_ctrl_e;

  localparam logic [1:0] PCSEL1_OFF11 = 2'b00;
  localparam logic [1:0] PCSEL1_OFF9  = 2'b01;
  localparam logic [1:0] PCSEL1_OFF6  = 2'b10;
  localparam logic [1:0] PCSEL1_ZERO  = 2'b11;

  // Replicates bit msb of val into every higher bit position.
  function automatic logic [15:0] sext16(input logic [15:0] val, input logic [3:0] msb);
    logic [15:0] res;
    res = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      if (i > int'(msb)) begin
        res[i] = val[msb];
      end else begin
        res[i] = val[i];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/lc3_exec_alu.sv
// Combinational ALU of the LC-3 execute stage (ADD / AND / NOT; reserved code yields zero).
module lc3_exec_alu
  import lc3_exec_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] val1,
  input  logic [DATA_W-1:0] op2,
  input  alu_ctrl_e         alu_control,
  output logic [DATA_W-1:0] result
);

  // Operation select; carry out of the adder is intentionally dropped.
  always_comb begin
    result = {DATA_W{1'b0}};
    case (alu_control)
      ALU_ADD: result = val1 + op2;
      ALU_AND: result = val1 & op2;
      ALU_NOT: result = ~val1;
      default: result = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/lc3_execute.sv
// LC-3 execute stage: operand forwarding, ALU, PC adder and pipeline registers.
// Forwarding muxes are built only when LC3_EXEC_BYPASS_EN is defined.
module lc3_execute
  import lc3_exec_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [5:0]        E_control,
  input  logic [DATA_W-1:0] IR,
  input  logic [DATA_W-1:0] npc_in,
  input  logic              bypass_alu_1,
  input  logic              bypass_alu_2,
  input  logic              bypass_mem_1,
  input  logic              bypass_mem_2,
  input  logic [DATA_W-1:0] VSR1,
  input  logic [DATA_W-1:0] VSR2,
  input  logic [1:0]        W_Control_in,
  input  logic              Mem_Control_in,
  input  logic              enable_execute,
  input  logic [DATA_W-1:0] Mem_Bypass_Val,
  output logic [DATA_W-1:0] aluout,
  output logic [DATA_W-1:0] pcout,
  output logic [DATA_W-1:0] M_Data,
  output logic [DATA_W-1:0] IR_Exec,
  output logic [2:0]        dr,
  output logic [2:0]        NZP,
  output logic [1:0]        W_Control_out,
  output logic              Mem_Control_out,
  output logic [2:0]        sr1,
  output logic [2:0]        sr2
);

  logic [3:0]        opcode_s;
  alu_ctrl_e         alu_control_s;
  logic [1:0]        pcselect1_s;
  logic [DATA_W-1:0] val1_s, val2_s, op2_s, alu_result_s;
  logic [DATA_W-1:0] offset_s, addend2_s, pc_sum_s, aluout_next_s;
  logic [2:0]        dr_next_s, nzp_next_s;

  assign opcode_s      = IR[15:12];
  assign alu_control_s = alu_ctrl_e'(E_control[5:4]);
  assign pcselect1_s   = E_control[3:2];
  assign sr1           = IR[8:6];

  // Store instructions read their data register from the DR field.
  always_comb begin
    if ((opcode_s == OP_ST) || (opcode_s == OP_STR) || (opcode_s == OP_STI)) begin
      sr2 = IR[11:9];
    end else begin
      sr2 = IR[2:0];
    end
  end

`ifdef LC3_EXEC_BYPASS_EN
  // Operand forwarding: ALU result is newer than the memory-stage value.
  always_comb begin
    if (bypass_alu_1) begin
      val1_s = aluout;
    end else if (bypass_mem_1) begin
      val1_s = Mem_Bypass_Val;
    end else begin
      val1_s = VSR1;
    end
    if (bypass_alu_2) begin
      val2_s = aluout;
    end else if (bypass_mem_2) begin
      val2_s = Mem_Bypass_Val;
    end else begin
      val2_s = VSR2;
    end
  end
`else
  logic unused_bypass_s;
  assign unused_bypass_s = ^{bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, Mem_Bypass_Val};
  assign val1_s = VSR1;
  assign val2_s = VSR2;
`endif

  assign op2_s = E_control[0] ? val2_s : sext16(IR, 4'd4);

  lc3_exec_alu #(.DATA_W(DATA_W)) u_alu (
    .val1        (val1_s),
    .op2         (op2_s),
    .alu_control (alu_control_s),
    .result      (alu_result_s)
  );

  // PC-relative offset select and address adder.
  always_comb begin
    offset_s = {DATA_W{1'b0}};
    case (pcselect1_s)
      PCSEL1_OFF11: offset_s = sext16(IR, 4'd10);
      PCSEL1_OFF9:  offset_s = sext16(IR, 4'd8);
      PCSEL1_OFF6:  offset_s = sext16(IR, 4'd5);
      default:      offset_s = {DATA_W{1'b0}};
    endcase
  end

  assign addend2_s = E_control[1] ? npc_in : val1_s;
  assign pc_sum_s  = addend2_s + offset_s;

  // Opcode-dependent next values for aluout, dr and NZP.
  always_comb begin
    aluout_next_s = aluout;
    dr_next_s     = 3'b000;
    nzp_next_s    = 3'b000;
    case (opcode_s)
      OP_ADD, OP_AND, OP_NOT: begin
        aluout_next_s = alu_result_s;
        dr_next_s     = IR[11:9];
      end
      OP_LEA: begin
        aluout_next_s = pc_sum_s;
        dr_next_s     = IR[11:9];
      end
      OP_LD, OP_LDR, OP_LDI: dr_next_s  = IR[11:9];
      OP_BR:                 nzp_next_s = IR[11:9];
      OP_JMP:                nzp_next_s = 3'b111;
      default: begin
        aluout_next_s = aluout;
        dr_next_s     = 3'b000;
        nzp_next_s    = 3'b000;
      end
    endcase
  end

  // Pipeline registers; a stall holds everything but drops NZP so a branch is taken once.
  always_ff @(posedge clock) begin
    if (reset) begin
      aluout          <= {DATA_W{1'b0}};
      pcout           <= {DATA_W{1'b0}};
      M_Data          <= {DATA_W{1'b0}};
      IR_Exec         <= {DATA_W{1'b0}};
      dr              <= 3'b000;
      NZP             <= 3'b000;
      W_Control_out   <= 2'b00;
      Mem_Control_out <= 1'b0;
    end else if (enable_execute) begin
      aluout          <= aluout_next_s;
      pcout           <= pc_sum_s;
      M_Data          <= val2_s;
      IR_Exec         <= IR;
      dr              <= dr_next_s;
      NZP             <= nzp_next_s;
      W_Control_out   <= W_Control_in;
      Mem_Control_out <= Mem_Control_in;
    end else begin
      NZP             <= 3'b000;
    end
  end

endmodule

// File: tb/tb_lc3_execute.sv
// Directed scoreboard bench for lc3_execute; expectations come from a reference
// model evaluated when each step is driven, plus fixed constants for key vectors.
module tb_lc3_execute;

  logic        clock = 1'b0;
  logic        reset, enable_execute;
  logic [5:0]  E_control;
  logic [15:0] IR, npc_in, VSR1, VSR2, Mem_Bypass_Val;
  logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
  logic [1:0]  W_Control_in;
  logic        Mem_Control_in;
  logic [15:0] aluout, pcout, M_Data, IR_Exec;
  logic [2:0]  dr, NZP, sr1, sr2;
  logic [1:0]  W_Control_out;
  logic        Mem_Control_out;

  typedef struct packed {
    logic [15:0] aluout;
    logic [15:0] pcout;
    logic [15:0] m_data;
    logic [15:0] ir_exec;
    logic [2:0]  dr;
    logic [2:0]  nzp;
    logic [1:0]  wc;
    logic        mc;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
  } exp_t;

  exp_t sb_q[$];
  exp_t st_m = '0;
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  lc3_execute #(.DATA_W(16)) dut (
    .clock(clock), .reset(reset), .E_control(E_control), .IR(IR), .npc_in(npc_in),
    .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
    .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2),
    .VSR1(VSR1), .VSR2(VSR2), .W_Control_in(W_Control_in), .Mem_Control_in(Mem_Control_in),
    .enable_execute(enable_execute), .Mem_Bypass_Val(Mem_Bypass_Val),
    .aluout(aluout), .pcout(pcout), .M_Data(M_Data), .IR_Exec(IR_Exec), .dr(dr), .NZP(NZP),
    .W_Control_out(W_Control_out), .Mem_Control_out(Mem_Control_out), .sr1(sr1), .sr2(sr2)
  );

  function automatic logic [15:0] sx(input logic [15:0] v, input int msb);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = (i > msb) ? v[msb] : v[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Evaluate the model for the driven inputs, clock once, then compare every output.
  task automatic step(input string name);
    exp_t e;
    logic [15:0] v1, v2, op2, alu, off, pc;
    logic [3:0]  opc;
    opc = IR[15:12];
    v1 = VSR1;
    v2 = VSR2;
`ifdef LC3_EXEC_BYPASS_EN
    if (bypass_alu_1) v1 = st_m.aluout; else if (bypass_mem_1) v1 = Mem_Bypass_Val;
    if (bypass_alu_2) v2 = st_m.aluout; else if (bypass_mem_2) v2 = Mem_Bypass_Val;
`endif
    op2 = E_control[0] ? v2 : sx(IR, 4);
    case (E_control[5:4])
      2'd0:    alu = v1 + op2;
      2'd1:    alu = v1 & op2;
      2'd2:    alu = ~v1;
      default: alu = 16'h0000;
    endcase
    case (E_control[3:2])
      2'd0:    off = sx(IR, 10);
      2'd1:    off = sx(IR, 8);
      2'd2:    off = sx(IR, 5);
      default: off = 16'h0000;
    endcase
    pc = (E_control[1] ? npc_in : v1) + off;
    e = st_m;
    if (reset) begin
      e = '0;
    end else if (!enable_execute) begin
      e.nzp = 3'b000;
    end else begin
      if (opc == 4'd1 || opc == 4'd5 || opc == 4'd9) e.aluout = alu;
      else if (opc == 4'd14) e.aluout = pc;
      e.pcout   = pc;
      e.m_data  = v2;
      e.ir_exec = IR;
      e.dr  = (opc inside {4'd1, 4'd2, 4'd5, 4'd6, 4'd9, 4'd10, 4'd14}) ? IR[11:9] : 3'b000;
      e.nzp = (opc == 4'd0) ? IR[11:9] : (opc == 4'd12) ? 3'b111 : 3'b000;
      e.wc  = W_Control_in;
      e.mc  = Mem_Control_in;
    end
    e.sr1 = IR[8:6];
    e.sr2 = (opc == 4'd3 || opc == 4'd7 || opc == 4'd11) ? IR[11:9] : IR[2:0];
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    chk({name, ".aluout"}, aluout, e.aluout);
    chk({name, ".pcout"}, pcout, e.pcout);
    chk({name, ".M_Data"}, M_Data, e.m_data);
    chk({name, ".IR_Exec"}, IR_Exec, e.ir_exec);
    chk({name, ".dr"}, {13'd0, dr}, {13'd0, e.dr});
    chk({name, ".NZP"}, {13'd0, NZP}, {13'd0, e.nzp});
    chk({name, ".W_Control_out"}, {14'd0, W_Control_out}, {14'd0, e.wc});
    chk({name, ".Mem_Control_out"}, {15'd0, Mem_Control_out}, {15'd0, e.mc});
    chk({name, ".sr1"}, {13'd0, sr1}, {13'd0, e.sr1});
    chk({name, ".sr2"}, {13'd0, sr2}, {13'd0, e.sr2});
    st_m = e;
  endtask

  initial begin
    reset = 1'b1; enable_execute = 1'b1; E_control = 6'b000000; IR = 16'h1261;
    npc_in = 16'h0000; VSR1 = 16'h0005; VSR2 = 16'h0000; Mem_Bypass_Val = 16'h0000;
    bypass_alu_1 = 1'b0; bypass_alu_2 = 1'b0; bypass_mem_1 = 1'b0; bypass_mem_2 = 1'b0;
    W_Control_in = 2'b11; Mem_Control_in = 1'b1;
    step("reset");
    chk("reset_aluout", aluout, 16'h0000);

    reset = 1'b0; W_Control_in = 2'b01; Mem_Control_in = 1'b0;
    step("add_imm");
    chk("add_imm_aluout", aluout, 16'h0006);
    chk("add_imm_dr", {13'd0, dr}, 16'h0001);

    IR = 16'h1443; E_control = 6'b000001; VSR1 = 16'h00A0; VSR2 = 16'h0050; W_Control_in = 2'b10;
    step("add_reg");
    chk("add_reg_aluout", aluout, 16'h00F0);

    IR = 16'h5042; E_control = 6'b010001; bypass_alu_1 = 1'b1; bypass_mem_1 = 1'b1;
    Mem_Bypass_Val = 16'hAAAA; VSR1 = 16'h0033; VSR2 = 16'h0FF0;
    step("and_fwd");
`ifdef LC3_EXEC_BYPASS_EN
    chk("and_fwd_alu_wins", aluout, 16'h00F0);
`else
    chk("and_nofwd", aluout, 16'h0030);
`endif

    IR = 16'h96BF; E_control = 6'b100000; bypass_alu_1 = 1'b0; Mem_Bypass_Val = 16'h0F0F;
    VSR1 = 16'h1234;
    step("not");
    bypass_mem_1 = 1'b0;

    IR = 16'h0E03; npc_in = 16'h3000; E_control = 6'b000110; Mem_Control_in = 1'b1;
    step("br");
    chk("br_pcout", pcout, 16'h3003);
    chk("br_nzp", {13'd0, NZP}, 16'h0007);

    enable_execute = 1'b0; IR = 16'h1261; npc_in = 16'h5000; W_Control_in = 2'b00;
    step("stall");
    chk("stall_nzp", {13'd0, NZP}, 16'h0000);
    chk("stall_pcout", pcout, 16'h3003);

    enable_execute = 1'b1; IR = 16'hE1FF; npc_in = 16'h0000; E_control = 6'b000110;
    step("lea_wrap");
    chk("lea_pcout", pcout, 16'hFFFF);
    chk("lea_aluout", aluout, 16'hFFFF);

    IR = 16'hC080; E_control = 6'b001100; VSR1 = 16'h4000;
    step("jmp");
    chk("jmp_pcout", pcout, 16'h4000);

    IR = 16'h1443; E_control = 6'b110001;
    step("alu_rsvd");

    IR = 16'h3400; E_control = 6'b000110; npc_in = 16'h3100; bypass_mem_2 = 1'b1;
    Mem_Bypass_Val = 16'hAAAA; VSR2 = 16'h1234;
    step("st");
`ifndef LC3_EXEC_BYPASS_EN
    chk("st_nobypass_mdata", M_Data, 16'h1234);
`endif
    chk("st_sr2", {13'd0, sr2}, 16'h0002);
    bypass_mem_2 = 1'b0;

    IR = 16'h6A85; E_control = 6'b001000; VSR1 = 16'h2000;
    step("ldr");

    reset = 1'b1; IR = 16'h1261; E_control = 6'b000000; VSR1 = 16'h0005;
    step("reset_mid");
    chk("reset_mid_aluout", aluout, 16'h0000);

    reset = 1'b0; VSR1 = 16'h0009;
    step("after_reset");
    chk("after_reset_aluout", aluout, 16'h000A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
